// File: rtl/ysyx_24090013_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24090013_seq_ctrl
// Description : Multi-cycle sequencer for the single-issue core
//               (IFU -> ID -> EXU -> WBU). It fetches one instruction per pass
//               and latches it for decode. It owns every cross-stage enable:
//               the PC load and the register-file write are allowed only in
//               the WB cycle. The core stops on ebreak, on a fetch access
//               fault, or when a fetch times out.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TO_W      width of the fetch-timeout counter; the timeout is 2**TO_W-1
//             cycles spent waiting for a response
//   RST_INST  value of inst_q after reset (nop)
// Ports
//   clk             in   1   core clock, rising edge
//   rst_n           in   1   synchronous active-low reset
//   ifu_req_valid   out  1   fetch request, held high only in FETCH
//   ifu_req_ready   in   1   memory accepts the request
//   ifu_rsp_valid   in   1   instruction data valid (single-cycle pulse)
//   ifu_rsp_inst    in   32  fetched instruction
//   ifu_rsp_err     in   1   access fault, qualified by ifu_rsp_valid
//   inst_q          out  32  latched instruction driven to decode
//   id_ebreak       in   1   decode reports the ebreak/ecall class
//   id_ebreak_good  in   1   1 = good trap
//   id_rd_wen       in   1   decode write-enable request
//   rf_wen          out  1   gated register-file write enable (WB only)
//   pc_wen          out  1   PC load enable (WB only)
//   halted          out  1   core stopped (sticky until reset)
//   halt_good       out  1   1 = good trap; valid while halted
//   state_o         out  3   current FSM state
// Optional feature (macro YSYX_24090013_PERF_EN)
//   perf_cycle      out  64  cycles elapsed while not halted
//   perf_instret    out  64  instructions retired (WB cycles)
// ============================================================================
module ysyx_24090013_seq_ctrl #(
    parameter int          TO_W     = 8,
    parameter logic [31:0] RST_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    input  logic        ifu_rsp_err,
    output logic [31:0] inst_q,
    input  logic        id_ebreak,
    input  logic        id_ebreak_good,
    input  logic        id_rd_wen,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halted,
    output logic        halt_good,
    output logic [2:0]  state_o
`ifdef YSYX_24090013_PERF_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DEC   = 3'd3,
        S_EXE   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    // The counter is compared before it increments. Matching 2**TO_W-2 in a
    // WAIT cycle with no response ends the wait after exactly 2**TO_W-1
    // cycles. The counter then reads 2**TO_W-1 as the FSM enters HALT and
    // can never wrap.
    localparam logic [TO_W-1:0] c_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TO_W-1:0]   r_cnt;
    logic [31:0]       r_inst;
    logic              r_halt_good;

    logic              w_latch;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_halt_good_nxt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;
        w_halt_good_nxt = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (ifu_req_ready) begin
                    w_cnt_clr = 1'b1;
                    // A response may arrive in the same cycle as the
                    // handshake. It is then handled exactly as in WAIT.
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_err) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_DEC;
                        end
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_inc = 1'b1;
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_DEC;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_DEC: begin
                if (id_ebreak) begin
                    w_state_nxt     = S_HALT;
                    w_halt_good_nxt = id_ebreak_good;
                end else begin
                    w_state_nxt = S_EXE;
                end
            end
            S_EXE:  w_state_nxt = S_WB;
            S_WB:   w_state_nxt = S_FETCH;
            S_HALT: w_state_nxt = S_HALT;
            // An unreachable encoding is treated as a bad-trap stop.
            default: w_state_nxt = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_inst      <= RST_INST;
            r_halt_good <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_latch) begin
                r_inst <= ifu_rsp_inst;
            end
            // The trap quality is captured only on entry to HALT, so it
            // stays stable while halted.
            if (r_state != S_HALT && w_state_nxt == S_HALT) begin
                r_halt_good <= w_halt_good_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all enables are decoded directly from the current state
    // ------------------------------------------------------------------------
    assign ifu_req_valid = (r_state == S_FETCH);
    assign pc_wen        = (r_state == S_WB);
    // Writes to x0 are dropped here so the register file never sees them.
    assign rf_wen        = (r_state == S_WB) && id_rd_wen && (r_inst[11:7] != 5'd0);
    assign halted        = (r_state == S_HALT);
    assign halt_good     = r_halt_good;
    assign inst_q        = r_inst;
    assign state_o       = r_state;

`ifdef YSYX_24090013_PERF_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_cycle   <= '0;
            r_perf_instret <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_perf_cycle <= r_perf_cycle + 64'd1;
            end
            if (r_state == S_WB) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090013_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24090013_seq_ctrl
// Description : Self-checking bench for ysyx_24090013_seq_ctrl. It applies a
//               table of instruction vectors and uses a scoreboard of
//               expected WB results. Hand-written sequences cover the
//               same-cycle response, ebreak, timeout, fetch error and reset
//               during WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090013_seq_ctrl;

    localparam int          TO_W     = 4;
    localparam logic [31:0] RST_INST = 32'h0000_0013;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DEC   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        ifu_rsp_err;
    logic [31:0] inst_q;
    logic        id_ebreak;
    logic        id_ebreak_good;
    logic        id_rd_wen;
    logic        rf_wen;
    logic        pc_wen;
    logic        halted;
    logic        halt_good;
    logic [2:0]  state_o;
`ifdef YSYX_24090013_PERF_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    always #5 clk = ~clk;

    ysyx_24090013_seq_ctrl #(
        .TO_W     (TO_W),
        .RST_INST (RST_INST)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_inst   (ifu_rsp_inst),
        .ifu_rsp_err    (ifu_rsp_err),
        .inst_q         (inst_q),
        .id_ebreak      (id_ebreak),
        .id_ebreak_good (id_ebreak_good),
        .id_rd_wen      (id_rd_wen),
        .rf_wen         (rf_wen),
        .pc_wen         (pc_wen),
        .halted         (halted),
        .halt_good      (halt_good),
        .state_o        (state_o)
`ifdef YSYX_24090013_PERF_EN
        ,
        .perf_cycle     (perf_cycle),
        .perf_instret   (perf_instret)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] inst;
        logic        rf;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] inst;
        logic        rd_wen;
        int          rdy_w;
        int          rsp_w;
        logic        exp_rf;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge. Any WB cycle
    // must match the oldest expected result in the scoreboard.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rf_wen) chk("rf_wen_outside_wb", {63'd0, pc_wen}, 64'd1);
        if (pc_wen) begin
            if (sb_q.size() == 0) begin
                chk("pc_wen_unexpected", {63'd0, pc_wen}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_inst_q", {32'd0, inst_q}, {32'd0, e.inst});
                chk("sb_rf_wen", {63'd0, rf_wen}, {63'd0, e.rf});
            end
        end
    endtask

    task automatic idle_inputs();
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b0;
        ifu_rsp_inst   = 32'h0;
        ifu_rsp_err    = 1'b0;
        id_ebreak      = 1'b0;
        id_ebreak_good = 1'b0;
        id_rd_wen      = 1'b0;
    endtask

    // Reset, check reset values, release, and step into the first FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        sb_q.delete();
        chk("rst_state",     {61'd0, state_o}, {61'd0, ST_IDLE});
        chk("rst_req_valid", {63'd0, ifu_req_valid}, 64'd0);
        chk("rst_inst_q",    {32'd0, inst_q}, {32'd0, RST_INST});
        chk("rst_enables",   {62'd0, rf_wen, pc_wen}, 64'd0);
        chk("rst_halted",    {62'd0, halted, halt_good}, 64'd0);
`ifdef YSYX_24090013_PERF_EN
        chk("rst_perf_cycle",   perf_cycle, 64'd0);
        chk("rst_perf_instret", perf_instret, 64'd0);
`endif
        rst_n = 1'b1;
        cyc   = 0;
        chk("cyc0_idle", {61'd0, state_o}, {61'd0, ST_IDLE});
        step();
        chk("cyc1_fetch", {61'd0, state_o}, {61'd0, ST_FETCH});
        chk("cyc1_req_valid", {63'd0, ifu_req_valid}, 64'd1);
    endtask

    // Run one instruction starting in FETCH. Returns the WB step and the
    // total steps back to FETCH, both counted from the FETCH entry.
    task automatic run_inst(input vec_t v, output int wb_at, output int total);
        int c0;
        c0 = cyc;
        wb_at = -1;
        id_rd_wen = v.rd_wen;
        id_ebreak = 1'b0;
        for (int i = 0; i < v.rdy_w; i++) begin
            ifu_req_ready = 1'b0;
            step();
            chk("stall_state", {61'd0, state_o}, {61'd0, ST_FETCH});
            chk("stall_req",   {63'd0, ifu_req_valid}, 64'd1);
            chk("stall_en",    {62'd0, rf_wen, pc_wen}, 64'd0);
        end
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        chk("hs_wait", {61'd0, state_o}, {61'd0, ST_WAIT});
        for (int i = 0; i < v.rsp_w; i++) begin
            step();
            chk("memwait_state", {61'd0, state_o}, {61'd0, ST_WAIT});
        end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = v.inst;
        sb_q.push_back('{v.inst, v.exp_rf});
        step();
        ifu_rsp_valid = 1'b0;
        chk("latch_dec",    {61'd0, state_o}, {61'd0, ST_DEC});
        chk("latch_inst_q", {32'd0, inst_q}, {32'd0, v.inst});
        for (int i = 0; i < 3 && wb_at < 0; i++) begin
            step();
            if (pc_wen) wb_at = cyc - c0;
        end
        step();
        chk("back_fetch", {61'd0, state_o}, {61'd0, ST_FETCH});
        total = cyc - c0;
    endtask

    int wb_at;
    int total;
    int k;
`ifdef YSYX_24090013_PERF_EN
    logic [63:0] pc_snap;
    logic [63:0] pi_snap;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        inst          rd_wen rdy rsp  rf
        vecs[0] = '{32'h0050_0093, 1'b1, 0, 0, 1'b1};  // addi x1,x0,5
        vecs[1] = '{32'h0000_0013, 1'b1, 0, 0, 1'b0};  // write to x0
        vecs[2] = '{32'h0020_81b3, 1'b1, 3, 0, 1'b1};  // add x3,x1,x2, ready low 3
        vecs[3] = '{32'h0020_8463, 1'b0, 0, 2, 1'b0};  // beq, no rd write
        vecs[4] = '{32'hfff0_0f93, 1'b1, 1, 1, 1'b1};  // addi x31,x0,-1

        do_reset();

        // The first vector also checks absolute timing from reset release.
        // FETCH is cycle 1, so WB falls on cycle 5 and FETCH resumes on cycle 6.
        for (int i = 0; i < 5; i++) begin
            run_inst(vecs[i], wb_at, total);
            chk("wb_step",   wb_at, 4 + vecs[i].rdy_w + vecs[i].rsp_w);
            chk("inst_cycles", total, 5 + vecs[i].rdy_w + vecs[i].rsp_w);
            if (i == 0) chk("first_refetch_cycle", cyc, 6);
        end
        chk("sb_drained", sb_q.size(), 0);
`ifdef YSYX_24090013_PERF_EN
        chk("perf_instret_5", perf_instret, 64'd5);
`endif

        // Response in the same cycle as the handshake: FETCH goes straight to DEC
        id_rd_wen     = 1'b1;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h00a0_0113;
        sb_q.push_back('{32'h00a0_0113, 1'b1});
        step();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        chk("same_cycle_dec",  {61'd0, state_o}, {61'd0, ST_DEC});
        chk("same_cycle_inst", {32'd0, inst_q}, 64'h00a0_0113);
        step();
        step();
        step();
        chk("same_cycle_fetch", {61'd0, state_o}, {61'd0, ST_FETCH});
        chk("same_cycle_sb",    sb_q.size(), 0);

        // ebreak (good trap): halt with no WB and no PC update
        id_ebreak      = 1'b1;
        id_ebreak_good = 1'b1;
        ifu_req_ready  = 1'b1;
        step();
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b1;
        ifu_rsp_inst   = 32'h0010_0073;
        step();
        ifu_rsp_valid  = 1'b0;
        step();
        chk("ebreak_state",     {61'd0, state_o}, {61'd0, ST_HALT});
        chk("ebreak_halted",    {63'd0, halted}, 64'd1);
        chk("ebreak_halt_good", {63'd0, halt_good}, 64'd1);
`ifdef YSYX_24090013_PERF_EN
        pc_snap = perf_cycle;
        pi_snap = perf_instret;
`endif
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hdead_beef;
        step();
        ifu_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("halt_ignores_rsp", {32'd0, inst_q}, 64'h0010_0073);
        chk("halt_absorbing",   {61'd0, state_o}, {61'd0, ST_HALT});
        chk("halt_no_req",      {63'd0, ifu_req_valid}, 64'd0);
        chk("halt_good_stable", {63'd0, halt_good}, 64'd1);
`ifdef YSYX_24090013_PERF_EN
        chk("perf_cycle_frozen",   perf_cycle, pc_snap);
        chk("perf_instret_frozen", perf_instret, pi_snap);
`endif

        // Timeout: with TO_W=4 the FSM halts 15 cycles after entering WAIT
        do_reset();
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        chk("to_wait", {61'd0, state_o}, {61'd0, ST_WAIT});
        k = 0;
        while (state_o != ST_HALT && k < 40) begin
            step();
            k++;
        end
        chk("timeout_cycles",   k, 15);
        chk("timeout_halted",   {63'd0, halted}, 64'd1);
        chk("timeout_halt_good", {63'd0, halt_good}, 64'd0);

        // Fetch error: halt as a bad trap and keep the old inst_q
        do_reset();
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_err   = 1'b1;
        ifu_rsp_inst  = 32'h1234_5678;
        step();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        chk("err_state",     {61'd0, state_o}, {61'd0, ST_HALT});
        chk("err_halt_good", {63'd0, halt_good}, 64'd0);
        chk("err_inst_q",    {32'd0, inst_q}, {32'd0, RST_INST});

        // Reset while in WAIT, with a stale response during reset
        do_reset();
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        chk("mid_wait", {61'd0, state_o}, {61'd0, ST_WAIT});
        rst_n         = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hdead_beef;
        step();
        ifu_rsp_valid = 1'b0;
        chk("midrst_state",  {61'd0, state_o}, {61'd0, ST_IDLE});
        chk("midrst_inst_q", {32'd0, inst_q}, {32'd0, RST_INST});
        chk("midrst_req",    {63'd0, ifu_req_valid}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_refetch", {61'd0, state_o}, {61'd0, ST_FETCH});
        for (int i = 0; i < 3; i++) begin
            run_inst(vecs[i], wb_at, total);
            chk("post_rst_cycles", total, 5 + vecs[i].rdy_w + vecs[i].rsp_w);
        end
`ifdef YSYX_24090013_PERF_EN
        chk("perf_instret_3", perf_instret, 64'd3);
`endif
        id_ebreak      = 1'b1;
        id_ebreak_good = 1'b0;
        ifu_req_ready  = 1'b1;
        step();
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b1;
        ifu_rsp_inst   = 32'h0010_0073;
        step();
        ifu_rsp_valid  = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        chk("bad_trap_state",     {61'd0, state_o}, {61'd0, ST_HALT});
        chk("bad_trap_halt_good", {63'd0, halt_good}, 64'd0);
`ifdef YSYX_24090013_PERF_EN
        chk("perf_instret_3_frozen", perf_instret, 64'd3);
`endif
        chk("final_sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
